// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: transmit FIFO between the APB write strobe and the SSP shifter.
// Bytes are pushed on PSEL & PWRITE and the head byte is offered to the
// shifter through tx_ready / TxData. One entry is popped on each rising edge
// of transmit_complete, which marks the end of a frame. Full and empty are
// told apart by the occupancy counter alone, so both pointers wrap freely.
module ssp_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          PCLK,
    input  logic          CLEAR_B,
    input  logic          PSEL,
    input  logic          PWRITE,
    input  logic [7:0]    PWDATA,
    input  logic          transmit_complete,
    output logic [7:0]    TxData,
    output logic          tx_ready,
    output logic          SSPTXINTR,
    output logic          tx_overflow,
    output logic [AW:0]   tx_count
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          tcPrev_q;
    logic          overflow_q, overflow_d;

    logic          isEmpty;
    logic          isFull;
    logic          popPending;
    logic          pop;
    logic          pushReq;
    logic          pushAccept;
    logic          pushDrop;

    // Handshake decode: a frame ends on the rising edge of transmit_complete.
    // The pending pop masks tx_ready so the shifter never restarts on the
    // byte that is about to leave, which costs one idle cycle between frames.
    always_comb begin
        isEmpty    = (count_q == '0);
        isFull     = (count_q == COUNT_FULL);
        popPending = transmit_complete & ~tcPrev_q;
        pop        = popPending & ~isEmpty;
        pushReq    = PSEL & PWRITE;
        pushAccept = pushReq & (~isFull | pop);
        pushDrop   = pushReq & isFull & ~pop;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    // A simultaneous push and pop moves both pointers and leaves count alone.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pushAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end

        unique case ({pushAccept, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        if (pushDrop) begin
            overflow_d = 1'b1;
        end
    end

    // Control registers with synchronous active-low clear. tcPrev resets high
    // so a transmit_complete that is already high after reset is not a pop.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            tcPrev_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            tcPrev_q   <= transmit_complete;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; no reset, and writes are held off while clearing.
    always_ff @(posedge PCLK) begin
        if (CLEAR_B && pushAccept) begin
            mem_q[wrPtr_q] <= PWDATA;
        end
    end

    // Outputs come straight from registers and the array at the read pointer.
    always_comb begin
        TxData      = mem_q[rdPtr_q];
        tx_ready    = ~isEmpty & ~popPending;
        SSPTXINTR   = isFull;
        tx_overflow = overflow_q;
        tx_count    = count_q;
    end

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: directed bench for the SSP transmit FIFO.
// Inputs change 1 time unit after a rising PCLK edge and outputs are checked
// 1 unit later, well away from the next edge.
module tb_ssp_tx_fifo;

    logic        PCLK = 1'b0;
    logic        CLEAR_B = 1'b0;
    logic        PSEL = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PWDATA = 8'h00;
    logic        transmit_complete = 1'b1;
    logic [7:0]  TxData;
    logic        tx_ready;
    logic        SSPTXINTR;
    logic        tx_overflow;
    logic [2:0]  tx_count;

    int compareCount = 0;
    int mismatchCount = 0;

    ssp_tx_fifo #(.DEPTH(4), .AW(2)) dut (
        .PCLK              (PCLK),
        .CLEAR_B           (CLEAR_B),
        .PSEL              (PSEL),
        .PWRITE            (PWRITE),
        .PWDATA            (PWDATA),
        .transmit_complete (transmit_complete),
        .TxData            (TxData),
        .tx_ready          (tx_ready),
        .SSPTXINTR         (SSPTXINTR),
        .tx_overflow       (tx_overflow),
        .tx_count          (tx_count)
    );

    // Free-running PCLK, period 10.
    always #5 PCLK = ~PCLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic clearB, input logic push,
                                 input logic [7:0] data, input logic tc);
        CLEAR_B = clearB;
        PSEL = push;
        PWRITE = push;
        PWDATA = data;
        transmit_complete = tc;
        #1;
    endtask

    // Advance one rising edge, then step 1 unit past it.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Push a single byte on the next edge, then release the strobe.
    task automatic pushByte(input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, data, transmit_complete);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, transmit_complete);
    endtask

    // Run one shifter frame: drop transmit_complete, then raise it and pop.
    task automatic runFrame(input int lowCycles, input string tag);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < lowCycles; i++) tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput({tag, "_readyMasked"}, 32'(tx_ready), 32'h0);
        tick();
    endtask

    // Main directed sequence.
    initial begin
        // Reset held for two edges with a push request active.
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
        tick();
        tick();
        checkOutput("rst_count", 32'(tx_count), 32'h0);
        checkOutput("rst_ready", 32'(tx_ready), 32'h0);
        checkOutput("rst_full", 32'(SSPTXINTR), 32'h0);
        checkOutput("rst_ovf", 32'(tx_overflow), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("rst_nothingStored", 32'(tx_count), 32'h0);

        // Single byte through a 9-cycle frame.
        pushByte(8'hA5);
        checkOutput("single_ready", 32'(tx_ready), 32'h1);
        checkOutput("single_data", 32'(TxData), 32'hA5);
        checkOutput("single_count", 32'(tx_count), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("frame_readyHeld", 32'(tx_ready), 32'h1);
        checkOutput("frame_dataHeld", 32'(TxData), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("frame_readyLowAtRise", 32'(tx_ready), 32'h0);
        checkOutput("frame_countBeforePop", 32'(tx_count), 32'h1);
        tick();
        checkOutput("frame_countAfterPop", 32'(tx_count), 32'h0);
        checkOutput("frame_readyAfterPop", 32'(tx_ready), 32'h0);

        // Fill to DEPTH, then one dropped push.
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        pushByte(8'h44);
        checkOutput("fill_count", 32'(tx_count), 32'h4);
        checkOutput("fill_full", 32'(SSPTXINTR), 32'h1);
        checkOutput("fill_head", 32'(TxData), 32'h11);
        checkOutput("fill_ovfClear", 32'(tx_overflow), 32'h0);
        pushByte(8'h55);
        checkOutput("ovf_flag", 32'(tx_overflow), 32'h1);
        checkOutput("ovf_count", 32'(tx_count), 32'h4);
        checkOutput("ovf_head", 32'(TxData), 32'h11);

        // Full FIFO: push 0x66 on the same edge as the pop of 0x11.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h66, 1'b1);
        checkOutput("fullPop_readyMasked", 32'(tx_ready), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("fullPop_count", 32'(tx_count), 32'h4);
        checkOutput("fullPop_head", 32'(TxData), 32'h22);
        checkOutput("fullPop_ovfSticky", 32'(tx_overflow), 32'h1);
        checkOutput("fullPop_ready", 32'(tx_ready), 32'h1);
        runFrame(3, "drain22");
        checkOutput("drain_head33", 32'(TxData), 32'h33);
        runFrame(3, "drain33");
        checkOutput("drain_head44", 32'(TxData), 32'h44);
        runFrame(3, "drain44");
        checkOutput("drain_head66", 32'(TxData), 32'h66);
        checkOutput("drain_count1", 32'(tx_count), 32'h1);
        runFrame(3, "drain66");
        checkOutput("drain_empty", 32'(tx_count), 32'h0);
        checkOutput("drain_readyEmpty", 32'(tx_ready), 32'h0);

        // Frame completion on an empty FIFO must not underflow.
        runFrame(2, "emptyFrame");
        checkOutput("emptyFrame_count", 32'(tx_count), 32'h0);

        // Interleaved push/frame, pointers wrapping past index 3.
        for (int b = 1; b <= 6; b++) begin
            pushByte(8'(b));
            checkOutput($sformatf("wrap%0d_data", b), 32'(TxData), 32'(b));
            checkOutput($sformatf("wrap%0d_ready", b), 32'(tx_ready), 32'h1);
            runFrame(4, $sformatf("wrap%0d", b));
            checkOutput($sformatf("wrap%0d_count", b), 32'(tx_count), 32'h0);
        end
        checkOutput("wrap_ovfSticky", 32'(tx_overflow), 32'h1);

        // Reset mid-frame with three bytes queued.
        pushByte(8'hA1);
        pushByte(8'hA2);
        pushByte(8'hA3);
        checkOutput("midRst_countBefore", 32'(tx_count), 32'h3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("midRst_count", 32'(tx_count), 32'h0);
        checkOutput("midRst_ready", 32'(tx_ready), 32'h0);
        checkOutput("midRst_ovfCleared", 32'(tx_overflow), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("midRst_readyTcHigh", 32'(tx_ready), 32'h0);
        tick();
        tick();
        checkOutput("midRst_countStays", 32'(tx_count), 32'h0);

        // FIFO is usable again after the mid-frame reset.
        pushByte(8'h5A);
        checkOutput("postRst_data", 32'(TxData), 32'h5A);
        checkOutput("postRst_ready", 32'(tx_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
